// File: rtl/lstm_fwd_seq.sv
`default_nettype none
// ============================================================================
//  Module      : lstm_fwd_seq
//  Description : Sequential single-cell LSTM forward pass. It latches an input
//                sequence, the gate weights and the biases on an accepted start.
//                It then walks TIMESTEP steps, using two cycles per step:
//                  GATE : compute the a/i/f/o activations.
//                  CELL : compute c/h and store the per-step words.
//                It publishes the packed per-step buses that the backprop
//                block consumes.
//  Ports       : clk, rst (async, active-high)
//                i_start                  - start request, sampled in IDLE
//                i_x                      - TIMESTEP*NUM input words
//                i_wa/i_wi/i_wf/i_wo      - gate weights (x lanes, then h)
//                i_b                      - biases {o,f,i,a}, a in word 0
//                o_x                      - per step {h_{t-1}, x lanes}
//                o_h/o_c/o_a/o_i/o_f/o_o  - per-step results, t=0 in word 0
//                o_busy, o_done           - run status / completion pulse
//  Revision    : 1.0 - initial release
// ============================================================================
module lstm_fwd_seq #(
    parameter int WIDTH    = 32,
    parameter int FRAC     = 24,
    parameter int TIMESTEP = 4,
    parameter int NUM      = 2,
    parameter int NUM_LSTM = 1
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   i_start,
    input  logic [TIMESTEP*NUM*WIDTH-1:0]          i_x,
    input  logic [(NUM+NUM_LSTM)*WIDTH-1:0]        i_wa,
    input  logic [(NUM+NUM_LSTM)*WIDTH-1:0]        i_wi,
    input  logic [(NUM+NUM_LSTM)*WIDTH-1:0]        i_wf,
    input  logic [(NUM+NUM_LSTM)*WIDTH-1:0]        i_wo,
    input  logic [4*WIDTH-1:0]                     i_b,
    output logic [TIMESTEP*(NUM+NUM_LSTM)*WIDTH-1:0] o_x,
    output logic [TIMESTEP*WIDTH-1:0]              o_h,
    output logic [TIMESTEP*WIDTH-1:0]              o_c,
    output logic [TIMESTEP*WIDTH-1:0]              o_a,
    output logic [TIMESTEP*WIDTH-1:0]              o_i,
    output logic [TIMESTEP*WIDTH-1:0]              o_f,
    output logic [TIMESTEP*WIDTH-1:0]              o_o,
    output logic                                   o_busy,
    output logic                                   o_done
);

    localparam int TW  = (TIMESTEP > 1) ? $clog2(TIMESTEP) : 1;
    localparam int XW  = (NUM + NUM_LSTM) * WIDTH;
    localparam logic [TW-1:0] C_T_LAST = TW'(TIMESTEP - 1);
    localparam logic signed [WIDTH-1:0] C_ONE  = WIDTH'(1) << FRAC;
    localparam logic signed [WIDTH-1:0] C_HALF = WIDTH'(1) << (FRAC - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_GATE = 2'd1;
    localparam logic [1:0] S_CELL = 2'd2;

    // Fixed-point multiply: full-width product, arithmetic shift, truncate.
    function automatic logic signed [WIDTH-1:0] fx_mul(input logic signed [WIDTH-1:0] a,
                                                       input logic signed [WIDTH-1:0] b);
        logic signed [2*WIDTH-1:0] p;
        p = (2*WIDTH)'(a) * (2*WIDTH)'(b);
        p = p >>> FRAC;
        return p[WIDTH-1:0];
    endfunction

    function automatic logic signed [WIDTH-1:0] sig_h(input logic signed [WIDTH-1:0] z);
        logic signed [WIDTH-1:0] s;
        s = (z >>> 2) + C_HALF;
        if (s < 0)          return '0;
        else if (s > C_ONE) return C_ONE;
        else                return s;
    endfunction

    function automatic logic signed [WIDTH-1:0] tanh_h(input logic signed [WIDTH-1:0] z);
        if (z < -C_ONE)     return -C_ONE;
        else if (z > C_ONE) return C_ONE;
        else                return z;
    endfunction

    logic [1:0]                     state_q, state_d;
    logic [TW-1:0]                  t_q;
    logic [TIMESTEP*NUM*WIDTH-1:0]  x_q;
    logic [XW-1:0]                  wa_q, wi_q, wf_q, wo_q;
    logic [4*WIDTH-1:0]             b_q;
    logic signed [WIDTH-1:0]        h_prev_q, c_prev_q;
    logic signed [WIDTH-1:0]        a_q, i_q, f_q, o_q;
    logic signed [WIDTH-1:0]        a_d, i_d, f_d, o_d, c_d, h_d;
    logic [XW-1:0]                  xcat_d;
    logic [TIMESTEP*XW-1:0]         ox_q;
    logic [TIMESTEP*WIDTH-1:0]      oh_q, oc_q, oa_q, oi_q, of_q, oo_q;
    logic                           done_q;
    logic                           accept, gate_en, cell_en, last;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    assign last = (t_q == C_T_LAST);

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (i_start) state_d = S_GATE;
            S_GATE:  state_d = S_CELL;
            S_CELL:  state_d = last ? S_IDLE : S_GATE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output / enable decode
    always_comb begin
        o_busy  = (state_q != S_IDLE);
        accept  = (state_q == S_IDLE) && i_start;
        gate_en = (state_q == S_GATE);
        cell_en = (state_q == S_CELL);
    end

    // Gate pre-activations and cell update for the current step
    always_comb begin
        logic signed [WIDTH-1:0] za, zi, zf, zo, xk;
        int tidx;
        tidx = int'(t_q);
        za = b_q[0*WIDTH +: WIDTH];
        zi = b_q[1*WIDTH +: WIDTH];
        zf = b_q[2*WIDTH +: WIDTH];
        zo = b_q[3*WIDTH +: WIDTH];
        for (int k = 0; k < NUM; k++) begin
            xk = x_q[(tidx*NUM + k)*WIDTH +: WIDTH];
            za = za + fx_mul(wa_q[k*WIDTH +: WIDTH], xk);
            zi = zi + fx_mul(wi_q[k*WIDTH +: WIDTH], xk);
            zf = zf + fx_mul(wf_q[k*WIDTH +: WIDTH], xk);
            zo = zo + fx_mul(wo_q[k*WIDTH +: WIDTH], xk);
        end
        za = za + fx_mul(wa_q[NUM*WIDTH +: WIDTH], h_prev_q);
        zi = zi + fx_mul(wi_q[NUM*WIDTH +: WIDTH], h_prev_q);
        zf = zf + fx_mul(wf_q[NUM*WIDTH +: WIDTH], h_prev_q);
        zo = zo + fx_mul(wo_q[NUM*WIDTH +: WIDTH], h_prev_q);
        a_d = tanh_h(za);
        i_d = sig_h(zi);
        f_d = sig_h(zf);
        o_d = sig_h(zo);
        // h_{t-1} sits above the x lanes so lane NUM carries it
        xcat_d = {h_prev_q, x_q[tidx*NUM*WIDTH +: NUM*WIDTH]};
        c_d = fx_mul(f_q, c_prev_q) + fx_mul(i_q, a_q);
        h_d = fx_mul(o_q, tanh_h(c_d));
    end

    // Datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            t_q <= '0; x_q <= '0; b_q <= '0;
            wa_q <= '0; wi_q <= '0; wf_q <= '0; wo_q <= '0;
            h_prev_q <= '0; c_prev_q <= '0;
            a_q <= '0; i_q <= '0; f_q <= '0; o_q <= '0;
            ox_q <= '0; oh_q <= '0; oc_q <= '0;
            oa_q <= '0; oi_q <= '0; of_q <= '0; oo_q <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= cell_en && last;
            if (accept) begin
                x_q  <= i_x;  b_q  <= i_b;
                wa_q <= i_wa; wi_q <= i_wi; wf_q <= i_wf; wo_q <= i_wo;
                t_q <= '0; h_prev_q <= '0; c_prev_q <= '0;
                ox_q <= '0; oh_q <= '0; oc_q <= '0;
                oa_q <= '0; oi_q <= '0; of_q <= '0; oo_q <= '0;
            end
            if (gate_en) begin
                a_q <= a_d; i_q <= i_d; f_q <= f_d; o_q <= o_d;
                ox_q[int'(t_q)*XW +: XW] <= xcat_d;
            end
            if (cell_en) begin
                oh_q[int'(t_q)*WIDTH +: WIDTH] <= h_d;
                oc_q[int'(t_q)*WIDTH +: WIDTH] <= c_d;
                oa_q[int'(t_q)*WIDTH +: WIDTH] <= a_q;
                oi_q[int'(t_q)*WIDTH +: WIDTH] <= i_q;
                of_q[int'(t_q)*WIDTH +: WIDTH] <= f_q;
                oo_q[int'(t_q)*WIDTH +: WIDTH] <= o_q;
                c_prev_q <= c_d;
                h_prev_q <= h_d;
                if (!last) t_q <= t_q + 1'b1;
            end
        end
    end

    assign o_x    = ox_q;
    assign o_h    = oh_q;
    assign o_c    = oc_q;
    assign o_a    = oa_q;
    assign o_i    = oi_q;
    assign o_f    = of_q;
    assign o_o    = oo_q;
    assign o_done = done_q;

endmodule
`default_nettype wire

// File: tb/tb_lstm_fwd_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lstm_fwd_seq
//  Description : Directed self-checking bench for lstm_fwd_seq with hand-computed
//                Q8.24 expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_lstm_fwd_seq;

    localparam int W = 32;
    localparam logic [31:0] C_ONE  = 32'h0100_0000;
    localparam logic [31:0] C_HALF = 32'h0080_0000;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            i_start = 1'b0;
    logic [255:0]    i_x = '0;
    logic [95:0]     i_wa = '0, i_wi = '0, i_wf = '0, i_wo = '0;
    logic [127:0]    i_b = '0;
    logic [383:0]    o_x;
    logic [127:0]    o_h, o_c, o_a, o_i, o_f, o_o;
    logic            o_busy, o_done;

    int passed = 0;
    int total  = 0;

    lstm_fwd_seq dut (
        .clk(clk), .rst(rst), .i_start(i_start), .i_x(i_x),
        .i_wa(i_wa), .i_wi(i_wi), .i_wf(i_wf), .i_wo(i_wo), .i_b(i_b),
        .o_x(o_x), .o_h(o_h), .o_c(o_c), .o_a(o_a), .o_i(o_i),
        .o_f(o_f), .o_o(o_o), .o_busy(o_busy), .o_done(o_done)
    );

    always #5 clk = ~clk;

    function automatic logic [127:0] rep4(input logic [31:0] v);
        return {v, v, v, v};
    endfunction

    // Expected o_x from the applied x and the expected h_{t-1} per step
    function automatic logic [383:0] exp_ox(input logic [255:0] x, input logic [127:0] hp);
        logic [383:0] r;
        for (int t = 0; t < 4; t++)
            r[t*96 +: 96] = {hp[t*W +: W], x[(t*2+1)*W +: W], x[t*2*W +: W]};
        return r;
    endfunction

    // Pulses start (caller is away from the edge) and returns cycles to o_done, -1 on timeout
    task automatic start_and_wait(output int lat);
        i_start = 1'b1;
        @(posedge clk); #1;
        i_start = 1'b0;
        lat = -1;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk); #1;
            if (o_done) begin lat = n; break; end
        end
    endtask

    task automatic load_zero_cfg();
        i_wa = '0; i_wi = '0; i_wf = '0; i_wo = '0; i_b = '0;
        i_x = {32'h0123_4567, 32'h89AB_CDEF, 32'hFF00_1234, 32'h0055_AA00,
               32'h7FFF_FFFF, 32'h8000_0000, 32'h0000_0001, 32'hDEAD_BEEF};
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++; if (o_busy !== 1'b0) $display("FAIL reset_busy got %0b want 0", o_busy); else passed++;
        total++; if (o_done !== 1'b0) $display("FAIL reset_done got %0b want 0", o_done); else passed++;
        total++; if ({o_x, o_h, o_c} !== '0) $display("FAIL reset_outs got nonzero want 0"); else passed++;
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        total++; if (o_busy !== 1'b0) $display("FAIL idle_busy got %0b want 0", o_busy); else passed++;
    endtask

    task automatic test_zero();
        int lat;
        load_zero_cfg();
        i_start = 1'b1;
        @(posedge clk); #1;
        i_start = 1'b0;
        total++; if (o_busy !== 1'b1) $display("FAIL zero_busy_e0 got %0b want 1", o_busy); else passed++;
        lat = -1;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk); #1;
            if (o_done) begin lat = n; break; end
        end
        total++; if (lat != 8) $display("FAIL zero_latency got %0d want 8", lat); else passed++;
        total++; if (o_busy !== 1'b0) $display("FAIL zero_busy_done got %0b want 0", o_busy); else passed++;
        total++; if (o_a !== '0) $display("FAIL zero_a got %h want 0", o_a); else passed++;
        total++; if ({o_i, o_f, o_o} !== {rep4(C_HALF), rep4(C_HALF), rep4(C_HALF)})
            $display("FAIL zero_ifo got %h %h %h want all 00800000", o_i, o_f, o_o); else passed++;
        total++; if ({o_c, o_h} !== '0) $display("FAIL zero_ch got %h %h want 0", o_c, o_h); else passed++;
        total++; if (o_x !== exp_ox(i_x, '0)) $display("FAIL zero_ox got %h want %h", o_x, exp_ox(i_x, '0)); else passed++;
        @(posedge clk); #1;
        total++; if (o_done !== 1'b0) $display("FAIL zero_done_width got %0b want 0", o_done); else passed++;
    endtask

    task automatic test_bias(input logic [31:0] bf, input bit accum);
        int lat;
        logic [127:0] ec, ef;
        i_wa = '0; i_wi = '0; i_wf = '0; i_wo = '0;
        i_b = {32'h0200_0000, bf, 32'h0200_0000, C_ONE};
        start_and_wait(lat);
        total++; if (lat != 8) $display("FAIL bias_latency got %0d want 8", lat); else passed++;
        ec = accum ? {32'h0400_0000, 32'h0300_0000, 32'h0200_0000, C_ONE} : rep4(C_ONE);
        ef = accum ? rep4(C_ONE) : '0;
        total++; if ({o_a, o_i, o_o} !== {rep4(C_ONE), rep4(C_ONE), rep4(C_ONE)})
            $display("FAIL bias_aio got %h %h %h want all 01000000", o_a, o_i, o_o); else passed++;
        total++; if (o_f !== ef) $display("FAIL bias_f got %h want %h", o_f, ef); else passed++;
        total++; if (o_c !== ec) $display("FAIL bias_c got %h want %h", o_c, ec); else passed++;
        total++; if (o_h !== rep4(C_ONE)) $display("FAIL bias_h got %h want %h", o_h, rep4(C_ONE)); else passed++;
        total++; if (o_x !== exp_ox(i_x, {C_ONE, C_ONE, C_ONE, 32'h0}))
            $display("FAIL bias_ox got %h want %h", o_x, exp_ox(i_x, {C_ONE, C_ONE, C_ONE, 32'h0})); else passed++;
    endtask

    task automatic load_wa_cfg();
        i_wa = {64'h0, C_HALF}; i_wi = '0; i_wf = '0; i_wo = '0; i_b = '0;
        i_x = '0;
        for (int t = 0; t < 4; t++) i_x[t*2*W +: W] = C_ONE;
    endtask

    task automatic check_wa_outputs();
        total++; if ({o_a, o_i} !== {rep4(C_HALF), rep4(C_HALF)})
            $display("FAIL wa_ai got %h %h want 00800000", o_a, o_i); else passed++;
        total++; if (o_c !== {32'h0078_0000, 32'h0070_0000, 32'h0060_0000, 32'h0040_0000})
            $display("FAIL wa_c got %h want 00780000_00700000_00600000_00400000", o_c); else passed++;
        total++; if (o_h !== {32'h003C_0000, 32'h0038_0000, 32'h0030_0000, 32'h0020_0000})
            $display("FAIL wa_h got %h want 003c0000_00380000_00300000_00200000", o_h); else passed++;
    endtask

    task automatic test_wa();
        int lat;
        load_wa_cfg();
        start_and_wait(lat);
        total++; if (lat != 8) $display("FAIL wa_latency got %0d want 8", lat); else passed++;
        check_wa_outputs();
    endtask

    task automatic test_back_to_back();
        int lat;
        load_wa_cfg();
        i_start = 1'b1;
        @(posedge clk); #1;
        i_start = 1'b0;
        lat = -1;
        for (int n = 1; n <= 20; n++) begin
            if (n == 2 || n == 5) begin
                i_start = 1'b1;
                i_b = {4{C_ONE}};
            end
            @(posedge clk); #1;
            i_start = 1'b0;
            if (o_done) begin lat = n; break; end
        end
        total++; if (lat != 8) $display("FAIL b2b_latency got %0d want 8", lat); else passed++;
        check_wa_outputs();
        // Restart in the done cycle with an all-zero configuration
        load_zero_cfg();
        i_start = 1'b1;
        @(posedge clk); #1;
        i_start = 1'b0;
        total++; if (o_done !== 1'b0 || o_busy !== 1'b1)
            $display("FAIL b2b_restart done/busy got %0b/%0b want 0/1", o_done, o_busy); else passed++;
        total++; if ({o_x, o_c, o_h} !== '0) $display("FAIL b2b_cleared got nonzero want 0"); else passed++;
        lat = -1;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk); #1;
            if (o_done) begin lat = n; break; end
        end
        total++; if (lat != 8) $display("FAIL b2b_second_latency got %0d want 8", lat); else passed++;
        total++; if (o_i !== rep4(C_HALF)) $display("FAIL b2b_second_i got %h want %h", o_i, rep4(C_HALF)); else passed++;
    endtask

    task automatic test_abort();
        int lat;
        bit saw_done;
        i_wa = '0; i_wi = '0; i_wf = '0; i_wo = '0;
        i_b = {32'h0200_0000, 32'h0200_0000, 32'h0200_0000, C_ONE};
        i_start = 1'b1;
        @(posedge clk); #1;
        i_start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        total++; if (o_busy !== 1'b0) $display("FAIL abort_busy got %0b want 0", o_busy); else passed++;
        total++; if ({o_x, o_c, o_h, o_a} !== '0) $display("FAIL abort_outs got nonzero want 0"); else passed++;
        @(negedge clk); rst = 1'b0;
        saw_done = 1'b0;
        for (int n = 0; n < 10; n++) begin
            @(posedge clk); #1;
            if (o_done) saw_done = 1'b1;
        end
        total++; if (saw_done) $display("FAIL abort_no_done got 1 want 0"); else passed++;
        load_zero_cfg();
        start_and_wait(lat);
        total++; if (lat != 8) $display("FAIL abort_rerun_latency got %0d want 8", lat); else passed++;
        total++; if ({o_a, o_i, o_c} !== {128'h0, rep4(C_HALF), 128'h0})
            $display("FAIL abort_rerun got a=%h i=%h c=%h", o_a, o_i, o_c); else passed++;
    endtask

    initial begin
        test_reset();
        test_zero();
        test_bias(32'hFE00_0000, 1'b0);
        test_bias(32'h0200_0000, 1'b1);
        test_wa();
        test_back_to_back();
        test_abort();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/lstm_fwd_seq.md
# lstm_fwd_seq

Sequential single-cell LSTM forward pass. Captures an input sequence, weights and biases on a start pulse, then steps through TIMESTEP timesteps, two cycles per step. Produces the packed per-timestep buses (x-concat, h, c, a, i, f, o) consumed by the backpropagation block. It is the forward-direction producer for the LSTM training datapath.

## Interface
- WIDTH, 32: word width, signed two's-complement fixed point
- FRAC, 24: fractional bits (1.0 = 1<<FRAC)
- TIMESTEP, 4: sequence length
- NUM, 2: external inputs per timestep
- NUM_LSTM, 1: recurrent lanes; only 1 is supported
- clk  in  1  clock; all state on rising edge
- rst  in  1  asynchronous, active-high reset
- i_start  in  1  start request, sampled only in IDLE
- i_x  in  TIMESTEP*NUM*WIDTH  inputs; timestep t, lane k at word t*NUM+k
- i_wa, i_wi, i_wf, i_wo  in  (NUM+NUM_LSTM)*WIDTH  gate weights; word k<NUM pairs x_k, word NUM pairs h_{t-1}
- i_b  in  4*WIDTH  biases; word 0=a, 1=i, 2=f, 3=o
- o_x  out  TIMESTEP*(NUM+NUM_LSTM)*WIDTH  per timestep: x lanes 0..NUM-1, then h_{t-1} at lane NUM
- o_h, o_c, o_a, o_i, o_f, o_o  out  TIMESTEP*WIDTH  per-timestep results; word t = timestep t, t=0 first
- o_busy  out  1  high while a sequence is running
- o_done  out  1  one-cycle pulse when all outputs are valid

## Operation
- FSM states:
  - IDLE: on i_start=1, latch i_x, weights and i_b; clear all output arrays to 0; reset h_prev=c_prev=0 and t=0; go to GATE.
  - GATE: compute z_g = b_g + sum_k w_g[k]*x_t[k] + w_g[NUM]*h_prev. Register a=tanh_h(z_a), i=sig_h(z_i), f=sig_h(z_f), o=sig_h(z_o). Write o_x word t. Go to CELL.
  - CELL: c=f*c_prev + i*a and h=o*tanh_h(c). Write words t of o_h, o_c, o_a, o_i, o_f, o_o. Set c_prev=c, h_prev=h.
    - If t=TIMESTEP-1: go to IDLE and assert o_done.
    - Otherwise: t=t+1 and go to GATE.
- Multiply: full 2*WIDTH signed product, arithmetic shift right by FRAC, truncate to WIDTH. No rounding.
- Add: WIDTH-bit wrap, no saturation.
- sig_h(z) = clamp((z>>>2) + 0.5, 0, 1.0).
- tanh_h(z) = clamp(z, -1.0, 1.0).
- Inputs are ignored except at the accepting edge. Changes to inputs mid-run have no effect.
- i_start while busy is ignored and is not queued.
- Output arrays hold their values after done until the next accepted start.

## Timing
- Reset: state=IDLE, t=0, o_busy=0, o_done=0. All output buses, h_prev and c_prev are 0.
- Reset mid-run aborts immediately. No o_done is produced and the partial outputs are zeroed.
- Start accepted at edge E0. o_busy=1 from E0.
- GATE occupies edges E1, E3, …; CELL occupies E2, E4, …
- o_done=1 and o_busy=0 after edge E(2*TIMESTEP); this is the latency (8 cycles at defaults). o_done drops at the next edge.
- Start asserted in the o_done cycle is accepted (state is IDLE). o_done still deasserts at that edge.
- o_x word t is valid from the GATE edge of step t. The other words for t are valid from the CELL edge of step t.

## Test plan
- All weights and biases 0, arbitrary x, start:
  - Every a=0, i=f=o=0x00800000, c=h=0, o_x lane 2=0.
  - o_done exactly 8 cycles after the start edge, for one cycle.
- Weights 0; b_a=1.0, b_i=2.0, b_f=-2.0, b_o=2.0:
  - a=i=o=0x01000000, f=0.
  - c=h=0x01000000 for all t.
  - o_x lane 2 = 0, 1.0, 1.0, 1.0.
- Same as previous but b_f=2.0:
  - c = 1.0, 2.0, 3.0, 4.0 (0x01000000…0x04000000).
  - h = 1.0 every step, due to tanh_h clamp.
- wa[0]=0.5, others 0, all biases 0, x_t[0]=1.0:
  - a=0x00800000, i=0x00800000.
  - c_t = 0.5*c_{t-1} + 0.25: 0x00400000, 0x00600000, 0x00700000, 0x00780000.
- Pulse start twice while busy:
  - Run completes once, latency 8, outputs unchanged.
  - Start in the done cycle begins a new run with cleared outputs.
- Assert rst at cycle 3 of a run:
  - Outputs and o_busy go to 0 asynchronously; no o_done.
  - A fresh start afterwards reproduces the first scenario's results.
